// File: rtl/smem_result_packer_pkg.sv
// Shared definitions for the SMEM result packer: lane field layout, compact
// entry format, header offsets and the FSM state encoding.
package smem_result_packer_pkg;

    localparam int LANE_W  = 256;
    localparam int ENTRY_W = 113;

    // Kept fields inside one 256-bit lane (LSB and width).
    localparam int F0_LO = 0;
    localparam int F0_W  = 33;
    localparam int F1_LO = 64;
    localparam int F1_W  = 33;
    localparam int F2_LO = 128;
    localparam int F2_W  = 33;
    localparam int F3_LO = 192;
    localparam int F3_W  = 7;
    localparam int F4_LO = 224;
    localparam int F4_W  = 7;

    // Matching offsets inside the compact 113-bit stored entry.
    localparam int E1_LO = F0_W;
    localparam int E2_LO = E1_LO + F1_W;
    localparam int E3_LO = E2_LO + F2_W;
    localparam int E4_LO = E3_LO + F3_W;

    localparam int HDR_NUM_LO  = 0;
    localparam int HDR_SIZE_LO = 64;
    localparam int HDR_RET_LO  = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_REQ,
        ST_HDR,
        ST_BODY,
        ST_FIN
    } state_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [LANE_W-1:0] d);
        pack_entry = {d[F4_LO +: F4_W], d[F3_LO +: F3_W], d[F2_LO +: F2_W],
                      d[F1_LO +: F1_W], d[F0_LO +: F0_W]};
    endfunction

    function automatic logic [LANE_W-1:0] unpack_entry(input logic [ENTRY_W-1:0] e);
        logic [LANE_W-1:0] lane;
        lane = '0;
        lane[F0_LO +: F0_W] = e[0     +: F0_W];
        lane[F1_LO +: F1_W] = e[E1_LO +: F1_W];
        lane[F2_LO +: F2_W] = e[E2_LO +: F2_W];
        lane[F3_LO +: F3_W] = e[E3_LO +: F3_W];
        lane[F4_LO +: F4_W] = e[E4_LO +: F4_W];
        return lane;
    endfunction

endpackage

// File: rtl/smem_result_packer_bank_ram.sv
// Simple dual-port bank RAM: one write port, one enabled read port with a
// registered (1-cycle) read data output.
module smem_bank_ram
    import smem_result_packer_pkg::*;
#(
    parameter int DW    = ENTRY_W,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/smem_result_packer.sv
// Collects per-read SMEM entries, sizes and return codes for a batch, then
// streams header + packed body beats per read once the output bus is granted.
module smem_result_packer
    import smem_result_packer_pkg::*;
#(
    parameter int READ_NUM_WIDTH = 8,
    parameter int READ_LEN       = 101,
    parameter int LANES          = 2,
    parameter int OUT_W          = 256 * LANES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      batch_start,
    input  logic [READ_NUM_WIDTH:0]   batch_size,
    input  logic                      mem_we,
    input  logic [READ_NUM_WIDTH-1:0] mem_read_num,
    input  logic [6:0]                mem_addr,
    input  logic [255:0]              mem_data,
    input  logic                      mem_size_valid,
    input  logic [READ_NUM_WIDTH-1:0] mem_size_read_num,
    input  logic [6:0]                mem_size,
    input  logic                      ret_valid,
    input  logic [READ_NUM_WIDTH-1:0] ret_read_num,
    input  logic [6:0]                ret,
    output logic                      out_request,
    input  logic                      out_permit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_finish,
    output logic                      size_err
);

    localparam int BANK_D = (READ_LEN + LANES - 1) / LANES;
    localparam int DEPTH  = (2 ** READ_NUM_WIDTH) * BANK_D;
    localparam int AW     = $clog2(DEPTH);

    state_t                    r_state;
    logic [READ_NUM_WIDTH:0]   r_batch_size, r_done_cnt;
    logic [READ_NUM_WIDTH-1:0] r_rd;
    logic [7:0]                r_beat;
    logic                      r_drain, r_request, r_finish, r_size_err;
    logic                      r_s1_valid, r_s1_hdr;
    logic [READ_NUM_WIDTH-1:0] r_s1_rd;
    logic [6:0]                r_s1_size, r_s1_ret;
    logic [7:0]                r_s1_beat;
    logic [6:0]                r_sizes [0:2**READ_NUM_WIDTH-1];
    logic [6:0]                r_rets  [0:2**READ_NUM_WIDTH-1];

    logic               w_collect, w_advance, w_streaming, w_issue, w_we, w_re;
    logic               w_last_read, w_oversize;
    logic [6:0]         w_cur_size, w_size_clamp;
    logic [7:0]         w_nbeats;
    logic [AW-1:0]      w_waddr, w_raddr;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata [LANES];
    logic [LANES-1:0]   w_bank_we, w_lane_on;

    assign w_collect    = (r_state == ST_COLLECT) && !batch_start;
    assign w_advance    = !r_s1_valid || out_ready;
    assign w_streaming  = (r_state == ST_HDR) || (r_state == ST_BODY);
    assign w_issue      = w_streaming && w_advance && !r_drain;
    assign w_cur_size   = r_sizes[r_rd];
    assign w_nbeats     = 8'((32'(w_cur_size) + LANES - 1) / LANES);
    assign w_last_read  = ({1'b0, r_rd} == r_batch_size - 1'b1);
    assign w_oversize   = 32'(mem_size) > READ_LEN;
    assign w_size_clamp = w_oversize ? 7'(READ_LEN) : mem_size;

    // Writes past the read's slot range would alias into the next read's area.
    assign w_we    = w_collect && mem_we && (32'(mem_addr) < READ_LEN);
    assign w_waddr = AW'(32'(mem_read_num) * BANK_D + 32'(mem_addr) / LANES);
    assign w_wdata = pack_entry(mem_data);
    assign w_re    = w_issue && (r_beat != 8'd0);
    assign w_raddr = AW'(32'(r_rd) * BANK_D + 32'(r_beat) - 1);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_bank
        assign w_bank_we[gi] = w_we && ((32'(mem_addr) % LANES) == gi);
        assign w_lane_on[gi] = (32'(r_s1_beat) * LANES + gi) < 32'(r_s1_size);

        smem_bank_ram #(.DW(ENTRY_W), .DEPTH(DEPTH), .AW(AW)) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .i_we    (w_bank_we[gi]),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_re    (w_re),
            .i_raddr (w_raddr),
            .o_rdata (w_rdata[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (w_collect && mem_size_valid) r_sizes[mem_size_read_num] <= w_size_clamp;
        if (w_collect && ret_valid)      r_rets[ret_read_num]       <= ret;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_batch_size <= '0;
            r_done_cnt   <= '0;
            r_rd         <= '0;
            r_beat       <= '0;
            r_drain      <= 1'b0;
            r_request    <= 1'b0;
            r_finish     <= 1'b0;
            r_size_err   <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_hdr     <= 1'b0;
            r_s1_rd      <= '0;
            r_s1_size    <= '0;
            r_s1_ret     <= '0;
            r_s1_beat    <= '0;
        end else if (batch_start) begin
            r_batch_size <= batch_size;
            r_done_cnt   <= '0;
            r_rd         <= '0;
            r_beat       <= '0;
            r_drain      <= 1'b0;
            r_request    <= 1'b0;
            r_size_err   <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_finish     <= (batch_size == '0);
            r_state      <= (batch_size == '0) ? ST_FIN : ST_COLLECT;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (mem_size_valid) begin
                        r_done_cnt <= r_done_cnt + 1'b1;
                        if (w_oversize) r_size_err <= 1'b1;
                    end
                    if (r_done_cnt == r_batch_size) begin
                        r_state   <= ST_REQ;
                        r_request <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (out_permit) begin
                        r_state   <= ST_HDR;
                        r_request <= 1'b0;
                    end
                end
                ST_HDR, ST_BODY: begin
                    if (w_advance && r_drain) begin
                        // Last beat has just been accepted (or slot is empty).
                        r_state    <= ST_FIN;
                        r_finish   <= 1'b1;
                        r_s1_valid <= 1'b0;
                    end else if (w_advance) begin
                        r_s1_valid <= 1'b1;
                        r_s1_hdr   <= (r_beat == 8'd0);
                        r_s1_rd    <= r_rd;
                        r_s1_size  <= w_cur_size;
                        r_s1_ret   <= r_rets[r_rd];
                        r_s1_beat  <= r_beat - 1'b1;
                        if (r_beat == w_nbeats) begin
                            r_beat  <= '0;
                            r_state <= ST_HDR;
                            if (w_last_read) r_drain <= 1'b1;
                            else             r_rd    <= r_rd + 1'b1;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                            r_state <= ST_BODY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        if (r_s1_valid && r_s1_hdr) begin
            out_data[HDR_NUM_LO  +: READ_NUM_WIDTH] = r_s1_rd;
            out_data[HDR_SIZE_LO +: 7]              = r_s1_size;
            out_data[HDR_RET_LO  +: 7]              = r_s1_ret;
        end else if (r_s1_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_lane_on[i]) out_data[i*LANE_W +: LANE_W] = unpack_entry(w_rdata[i]);
            end
        end
    end

    assign out_valid   = r_s1_valid;
    assign out_request = r_request;
    assign out_finish  = r_finish;
    assign size_err    = r_size_err;

endmodule

// File: tb/tb_smem_result_packer.sv
// Directed bench for smem_result_packer (LANES=2, READ_LEN=101): expected
// beats are queued as reads are loaded and checked by an independent monitor.
module tb_smem_result_packer;

    localparam int RNW   = 8;
    localparam int RLEN  = 101;
    localparam int LANES = 2;
    localparam int OUT_W = 256 * LANES;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             batch_start;
    logic [RNW:0]     batch_size;
    logic             mem_we;
    logic [RNW-1:0]   mem_read_num;
    logic [6:0]       mem_addr;
    logic [255:0]     mem_data;
    logic             mem_size_valid;
    logic [RNW-1:0]   mem_size_read_num;
    logic [6:0]       mem_size;
    logic             ret_valid;
    logic [RNW-1:0]   ret_read_num;
    logic [6:0]       ret;
    logic             out_request;
    logic             out_permit;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_finish;
    logic             size_err;

    int               cmps = 0;
    int               errs = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] exp_beat;
    logic [255:0]     model [0:3][0:127];
    logic             req_seen = 1'b0;
    logic             hold_pending = 1'b0;
    logic [OUT_W-1:0] hold_data;

    always #5 clk = ~clk;

    smem_result_packer #(.READ_NUM_WIDTH(RNW), .READ_LEN(RLEN), .LANES(LANES)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .batch_start       (batch_start),
        .batch_size        (batch_size),
        .mem_we            (mem_we),
        .mem_read_num      (mem_read_num),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .mem_size_valid    (mem_size_valid),
        .mem_size_read_num (mem_size_read_num),
        .mem_size          (mem_size),
        .ret_valid         (ret_valid),
        .ret_read_num      (ret_read_num),
        .ret               (ret),
        .out_request       (out_request),
        .out_permit        (out_permit),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_finish        (out_finish),
        .size_err          (size_err)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] keep_bits(input logic [255:0] d);
        logic [255:0] k;
        k = '0;
        for (int b = 0; b < 256; b++) begin
            if (b <= 32 || (b >= 64 && b <= 96) || (b >= 128 && b <= 160) ||
                (b >= 192 && b <= 198) || (b >= 224 && b <= 230)) k[b] = d[b];
        end
        return k;
    endfunction

    function automatic logic [255:0] pattern(input int r, input int k, input int salt);
        return {8{8'(salt), 8'(r), 8'(k), 8'(k * 7 + r * 3 + salt)}} ^ {4{64'hF0F0_3C3C_A5A5_0FF0}};
    endfunction

    // Monitor: hold-stability and in-order comparison of every accepted beat.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_pending = 1'b0;
        end else begin
            if (out_request) req_seen = 1'b1;
            if (hold_pending) begin
                check_bit("hold_valid", out_valid, 1'b1);
                check_vec("hold_data", out_data, hold_data);
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    cmps++;
                    errs++;
                    $display("FAIL unexpected_beat: got %0h expected none", out_data);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check_vec("beat", out_data, exp_beat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input int n);
        batch_start = 1'b1;
        batch_size  = (RNW + 1)'(n);
        tick();
        batch_start = 1'b0;
    endtask

    // Entry writes; size and return code coincide with the final entry write.
    task automatic collect_read(input int r, input int n_ent, input int size, input int rc, input int salt);
        for (int k = 0; k < n_ent; k++) begin
            model[r][k]  = pattern(r, k, salt);
            mem_we       = 1'b1;
            mem_read_num = RNW'(r);
            mem_addr     = 7'(k);
            mem_data     = model[r][k];
            if (k == n_ent - 1) begin
                mem_size_valid = 1'b1; mem_size_read_num = RNW'(r); mem_size = 7'(size);
                ret_valid      = 1'b1; ret_read_num      = RNW'(r); ret      = 7'(rc);
            end
            tick();
        end
        if (n_ent == 0) begin
            mem_size_valid = 1'b1; mem_size_read_num = RNW'(r); mem_size = 7'(size);
            ret_valid      = 1'b1; ret_read_num      = RNW'(r); ret      = 7'(rc);
            tick();
        end
        mem_we = 1'b0; mem_size_valid = 1'b0; ret_valid = 1'b0;
    endtask

    task automatic push_read(input int r, input int size, input int rc);
        logic [OUT_W-1:0] b;
        b = '0;
        b[7:0]     = 8'(r);
        b[70:64]   = 7'(size);
        b[134:128] = 7'(rc);
        exp_q.push_back(b);
        for (int bi = 0; bi < (size + 1) / 2; bi++) begin
            b = '0;
            for (int i = 0; i < 2; i++) begin
                if (bi * 2 + i < size) b[i*256 +: 256] = keep_bits(model[r][bi * 2 + i]);
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic grant();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_request;
        end
        check_bit("request_seen", seen, 1'b1);
        out_permit = 1'b1;
        tick();
        out_permit = 1'b0;
    endtask

    task automatic wait_valid();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check_bit("valid_seen", seen, 1'b1);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
        check_bit("queue_drained", exp_q.size() == 0, 1'b1);
    endtask

    task automatic wait_finish(input int bound);
        for (int i = 0; i < bound && !out_finish; i++) tick();
        check_bit("finish", out_finish, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; batch_start = 1'b0; batch_size = '0;
        mem_we = 1'b0; mem_read_num = '0; mem_addr = '0; mem_data = '0;
        mem_size_valid = 1'b0; mem_size_read_num = '0; mem_size = '0;
        ret_valid = 1'b0; ret_read_num = '0; ret = '0;
        out_permit = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check_bit("rst_valid", out_valid, 1'b0);
        check_bit("rst_request", out_request, 1'b0);
        check_bit("rst_finish", out_finish, 1'b0);
        check_bit("rst_size_err", size_err, 1'b0);
        check_vec("rst_data", out_data, '0);
        reset_n = 1'b1;
        repeat (2) tick();
        check_bit("idle_valid", out_valid, 1'b0);

        // Two reads, sizes {3,0}, rets {5,9}, back-to-back beats.
        start_batch(2);
        collect_read(0, 3, 3, 5, 1);
        collect_read(1, 0, 0, 9, 1);
        push_read(0, 3, 5);
        push_read(1, 0, 9);
        grant();
        wait_valid();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_bit("no_gap", out_valid, 1'b1);
        end
        @(negedge clk);
        check_bit("finish_next", out_finish, 1'b1);
        check_bit("fin_valid", out_valid, 1'b0);
        tick();
        check_bit("a_drained", exp_q.size() == 0, 1'b1);

        // out_ready toggling 1010 across a read-to-read transition.
        start_batch(2);
        collect_read(0, 6, 6, 7, 2);
        collect_read(1, 1, 1, 11, 2);
        push_read(0, 6, 7);
        push_read(1, 1, 11);
        grant();
        for (int c = 0; c < 60 && !(exp_q.size() == 0 && out_finish); c++) begin
            out_ready = (c % 2 == 0);
            tick();
        end
        out_ready = 1'b1;
        wait_drain(20);
        wait_finish(10);

        // Oversize: 120 clamps to 101, 51 body beats.
        start_batch(1);
        collect_read(0, 101, 120, 4, 3);
        tick();
        check_bit("size_err_set", size_err, 1'b1);
        push_read(0, 101, 4);
        grant();
        wait_drain(200);
        wait_finish(10);

        // Empty batch.
        req_seen = 1'b0;
        start_batch(0);
        begin
            logic fin;
            fin = 1'b0;
            for (int i = 0; i <= 2 && !fin; i++) begin
                fin = out_finish;
                if (!fin) tick();
            end
            check_bit("empty_finish", fin, 1'b1);
        end
        check_bit("size_err_cleared", size_err, 1'b0);
        repeat (5) tick();
        check_bit("empty_no_request", req_seen, 1'b0);
        check_bit("empty_valid", out_valid, 1'b0);

        // Write arriving during BODY must not alter streamed data.
        start_batch(1);
        collect_read(0, 5, 5, 3, 4);
        push_read(0, 5, 3);
        out_ready = 1'b0;
        grant();
        wait_valid();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        mem_we = 1'b1; mem_read_num = '0; mem_addr = 7'd4; mem_data = ~pattern(0, 4, 4);
        mem_size_valid = 1'b1; mem_size_read_num = '0; mem_size = 7'd1;
        tick();
        mem_we = 1'b0; mem_size_valid = 1'b0;
        repeat (2) tick();
        out_ready = 1'b1;
        wait_drain(20);
        wait_finish(10);

        // Reset mid-body, then a clean replay.
        start_batch(1);
        collect_read(0, 6, 6, 2, 5);
        push_read(0, 6, 2);
        grant();
        wait_valid();
        tick();
        out_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        check_bit("midrst_valid", out_valid, 1'b0);
        check_vec("midrst_data", out_data, '0);
        check_bit("midrst_request", out_request, 1'b0);
        check_bit("midrst_finish", out_finish, 1'b0);
        exp_q.delete();
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        check_bit("post_rst_idle", out_valid, 1'b0);
        start_batch(2);
        collect_read(0, 3, 3, 5, 6);
        collect_read(1, 0, 0, 9, 6);
        push_read(0, 3, 5);
        push_read(1, 0, 9);
        grant();
        wait_drain(20);
        wait_finish(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

    initial begin
        #500000;
        cmps++;
        errs++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
